// File: rtl/dma_copy.sv
// Byte-at-a-time memory copy engine acting as a bus initiator.
// Each byte: read strobe, wait states, write strobe, write hold.
module dma_copy #(
    parameter int WAIT_STATES = 0
) (
    input  logic        cpu_clk,
    input  logic        cpu_reset,
    input  logic        start,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [15:0] dma_addr_o,
    output logic        dma_oe_o,
    output logic        dma_we_o,
    input  logic [7:0]  dma_data_i,
    output logic [7:0]  dma_data_o
);

    typedef enum logic [2:0] {
        IDLE, RD, RDW, WR, WRH, FIN
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    state_t      state, state_n;
    logic [15:0] src_ptr, dst_ptr, cnt, addr_q;
    logic [7:0]  data_q;
    logic [3:0]  wait_cnt;
    logic        wait_last;

    assign wait_last  = (wait_cnt == WAIT_LAST);
    assign dma_addr_o = addr_q;
    assign dma_data_o = data_q;

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        done     = 1'b0;
        dma_oe_o = 1'b0;
        dma_we_o = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = (len == 16'd0) ? FIN : RD;
            end
            RD: begin
                busy     = 1'b1;
                dma_oe_o = 1'b1;
                state_n  = RDW;
            end
            RDW: begin
                busy = 1'b1;
                if (wait_last)
                    state_n = WR;
            end
            WR: begin
                busy     = 1'b1;
                dma_we_o = 1'b1;
                state_n  = WRH;
            end
            WRH: begin
                busy    = 1'b1;
                state_n = (cnt == 16'd1) ? FIN : RD;
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Address/data are registered so they hold between strobes.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state    <= IDLE;
            src_ptr  <= 16'd0;
            dst_ptr  <= 16'd0;
            cnt      <= 16'd0;
            addr_q   <= 16'd0;
            data_q   <= 8'd0;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start && len != 16'd0) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        cnt     <= len;
                        addr_q  <= src;
                    end
                end
                RD: wait_cnt <= 4'd0;
                RDW: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_last) begin
                        data_q <= dma_data_i;
                        addr_q <= dst_ptr;
                    end
                end
                WRH: begin
                    src_ptr <= src_ptr + 16'd1;
                    dst_ptr <= dst_ptr + 16'd1;
                    cnt     <= cnt - 16'd1;
                    if (cnt != 16'd1)
                        addr_q <= src_ptr + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
